pcp_chip: RTL and testbench

Pitch-class-profile (PCP) accumulator for the PCPIP datapath. It consumes an AXI4-Stream of (pitch-class key, energy) beat pairs, sums the energy into 12 per-pitch-class bins, and emits the 12-bin PCP vector as a 12-beat AXI4-Stream frame when the input frame ends. It sits between the upstream spectral/peak stage (AXI4-Stream master) and the downstream consumer (AXI4-Stream slave). The simulation wrapper connects master and slave VIPs to its two stream ports.

---
 rtl/pcp_pkg.sv | 23 ++
 rtl/pcp_bin_accum.sv | 55 +++++
 rtl/pcp_chip.sv | 140 ++++++++++++++
 tb/tb_pcp_chip.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcp_pkg.sv
// Shared constants, state encoding and key helper for the pitch-class-profile accumulator.
package pcp_pkg;

    localparam int unsigned NUM_BINS = 12;
    localparam int unsigned KEY_MIN  = 1;
    localparam int unsigned KEY_MAX  = 12;
    localparam int unsigned IDX_W    = 4;

    localparam int unsigned DEF_DATA_W = 512;
    localparam int unsigned DEF_VAL_W  = 16;
    localparam int unsigned DEF_ACC_W  = 24;

    typedef enum logic [1:0] {
        ST_KEY,
        ST_VAL,
        ST_EMIT
    } pcp_state_e;

    function automatic logic key_valid(input logic [7:0] key);
        return (key >= 8'(KEY_MIN)) && (key <= 8'(KEY_MAX));
    endfunction

endpackage

// File: rtl/pcp_bin_accum.sv
// Bank of NUM_BINS saturating accumulators with one add port, one read port and a bulk clear.
module pcp_bin_accum
    import pcp_pkg::*;
#(
    parameter int unsigned VAL_W = DEF_VAL_W,
    parameter int unsigned ACC_W = DEF_ACC_W
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             clr,
    input  logic             add_en,
    input  logic [IDX_W-1:0] add_idx,
    input  logic [VAL_W-1:0] add_val,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [ACC_W-1:0] rd_data
);

    localparam logic [ACC_W-1:0] ACC_MAX = '1;
    localparam logic [IDX_W-1:0] BIN_CNT = IDX_W'(NUM_BINS);

    logic [ACC_W-1:0] bins_q [NUM_BINS];
    logic [ACC_W-1:0] bins_d [NUM_BINS];
    logic [ACC_W:0]   sum;

    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_BINS; i++) begin
            bins_d[i] = bins_q[i];
        end
        if (clr) begin
            for (int i = 0; i < NUM_BINS; i++) begin
                bins_d[i] = '0;
            end
        end else if (add_en && (add_idx < BIN_CNT)) begin
            // One extra bit catches the carry so the bin clamps instead of wrapping.
            sum = {1'b0, bins_q[add_idx]} + (ACC_W + 1)'(add_val);
            bins_d[add_idx] = sum[ACC_W] ? ACC_MAX : sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_BINS; i++) begin
                bins_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BINS; i++) begin
                bins_q[i] <= bins_d[i];
            end
        end
    end

    assign rd_data = (rd_idx < BIN_CNT) ? bins_q[rd_idx] : '0;

endmodule

// File: rtl/pcp_chip.sv
// PCP accumulator: sums (key, energy) stream pairs into 12 pitch-class bins and emits the
// 12-bin vector as one output frame whenever the input frame ends.
module pcp_chip
    import pcp_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned VAL_W  = DEF_VAL_W,
    parameter int unsigned ACC_W  = DEF_ACC_W
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BINS - 1);

    pcp_state_e       state_q, state_d;
    logic             run_q;
    logic [7:0]       key_q;
    logic [IDX_W-1:0] idx_q;
    logic             m_valid_q;
    logic             m_last_q;

    logic             s_acc;
    logic             m_acc;
    logic             key_ld;
    logic             add_en;
    logic             emit_start;
    logic             emit_done;
    logic [IDX_W-1:0] add_idx;
    logic [ACC_W-1:0] rd_data;
    logic             unused_tdata;

    assign s_acc   = s_axis_tvalid & s_axis_tready;
    assign m_acc   = m_valid_q & m_axis_tready;
    assign add_idx = key_q[IDX_W-1:0] - IDX_W'(KEY_MIN);

    assign unused_tdata = ^s_axis_tdata[DATA_W-1:VAL_W];

    // State register
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= ST_KEY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_KEY:  if (s_acc) state_d = s_axis_tlast ? ST_EMIT : ST_VAL;
            ST_VAL:  if (s_acc) state_d = s_axis_tlast ? ST_EMIT : ST_KEY;
            ST_EMIT: if (emit_done) state_d = ST_KEY;
            default: state_d = ST_KEY;
        endcase
    end

    // FSM outputs; run_q holds ready low through reset and releases it one edge later
    always_comb begin
        s_axis_tready = 1'b0;
        key_ld        = 1'b0;
        add_en        = 1'b0;
        emit_start    = 1'b0;
        emit_done     = 1'b0;
        unique case (state_q)
            ST_KEY: begin
                s_axis_tready = run_q;
                key_ld        = s_acc & ~s_axis_tlast;
                emit_start    = s_acc & s_axis_tlast;
            end
            ST_VAL: begin
                s_axis_tready = run_q;
                add_en        = s_acc & key_valid(key_q);
                emit_start    = s_acc & s_axis_tlast;
            end
            ST_EMIT: begin
                emit_done = m_acc & (idx_q == LAST_IDX);
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            run_q     <= 1'b0;
            key_q     <= '0;
            idx_q     <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (key_ld) begin
                key_q <= s_axis_tdata[7:0];
            end
            if (emit_start) begin
                m_valid_q <= 1'b1;
                m_last_q  <= 1'b0;
                idx_q     <= '0;
            end else if (m_acc) begin
                if (idx_q == LAST_IDX) begin
                    m_valid_q <= 1'b0;
                    m_last_q  <= 1'b0;
                    idx_q     <= '0;
                end else begin
                    idx_q    <= idx_q + 1'b1;
                    m_last_q <= (idx_q == LAST_IDX - 1'b1);
                end
            end
        end
    end

    pcp_bin_accum #(
        .VAL_W (VAL_W),
        .ACC_W (ACC_W)
    ) u_bins (
        .aclk    (aclk),
        .aresetn (aresetn),
        .clr     (emit_done),
        .add_en  (add_en),
        .add_idx (add_idx),
        .add_val (s_axis_tdata[VAL_W-1:0]),
        .rd_idx  (idx_q),
        .rd_data (rd_data)
    );

    // Bins are frozen during emit, so this mux of registers is stable while stalled.
    assign m_axis_tdata  = m_valid_q ? DATA_W'(rd_data) : '0;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;

endmodule

// File: tb/tb_pcp_chip.sv
// Self-checking bench for pcp_chip: model-driven scoreboard plus a table of one-pair frames.
module tb_pcp_chip;

    localparam int DATA_W = 512;
    localparam int VAL_W  = 16;
    localparam int ACC_W  = 24;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic [DATA_W-1:0] s_axis_tdata = '0;
    logic              s_axis_tvalid = 1'b0;
    logic              s_axis_tlast = 1'b0;
    logic              s_axis_tready;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready = 1'b1;

    always #5 aclk = ~aclk;

    pcp_chip #(
        .DATA_W (DATA_W),
        .VAL_W  (VAL_W),
        .ACC_W  (ACC_W)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
    );

    typedef struct {
        logic [ACC_W-1:0] val;
        logic             last;
    } exp_t;

    typedef struct {
        logic [7:0]       key;
        logic [15:0]      val;
        int               bin;
        logic [ACC_W-1:0] expv;
    } vec_t;

    exp_t             exp_q[$];
    int               checks = 0;
    int               errors = 0;
    int               out_beats = 0;
    logic [ACC_W-1:0] model [12];
    logic             bp_en = 1'b0;
    int               bp_cnt = 0;
    vec_t             vecs [9];

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Downstream ready: either steady high or 2 low / 6 high.
    always @(negedge aclk) begin
        if (bp_en) begin
            m_axis_tready = (bp_cnt >= 2);
            bp_cnt = (bp_cnt + 1) % 8;
        end else begin
            m_axis_tready = 1'b1;
            bp_cnt = 0;
        end
    end

    // Output monitor: sampled mid low phase, after ready settles and before the next edge.
    logic              hold_v = 1'b0;
    logic [DATA_W-1:0] hold_d;
    logic              hold_l;
    always begin
        exp_t e;
        @(negedge aclk);
        #2;
        if (!aresetn) begin
            hold_v = 1'b0;
        end else if (m_axis_tvalid) begin
            if (hold_v) begin
                chk("stall_tdata", m_axis_tdata, hold_d);
                chk("stall_tlast", m_axis_tlast, hold_l);
            end
            if (m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got tdata 0x%0h, expected no beat", m_axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_tdata", m_axis_tdata, DATA_W'(e.val));
                    chk("out_tlast", m_axis_tlast, e.last);
                end
                out_beats++;
                hold_v = 1'b0;
            end else begin
                hold_v = 1'b1;
                hold_d = m_axis_tdata;
                hold_l = m_axis_tlast;
            end
        end else begin
            if (hold_v) chk("stall_tvalid", m_axis_tvalid, 1);
            hold_v = 1'b0;
        end
    end

    function automatic logic [DATA_W-1:0] noisy(input logic [15:0] lo, input bit key_beat);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom();
        if (key_beat) d[7:0] = lo[7:0];
        else d[15:0] = lo;
        return d;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 12; i++) model[i] = '0;
    endtask

    task automatic model_val(input logic [7:0] k, input logic [15:0] v);
        int unsigned s;
        if (k >= 1 && k <= 12) begin
            s = int'(model[k-1]) + int'(v);
            if (s > 32'h00FF_FFFF) s = 32'h00FF_FFFF;
            model[k-1] = s[ACC_W-1:0];
        end
    endtask

    task automatic push_model();
        exp_t e;
        for (int i = 0; i < 12; i++) begin
            e.val  = model[i];
            e.last = (i == 11);
            exp_q.push_back(e);
        end
        model_clear();
    endtask

    // Call during the low phase; returns at the negedge after the beat is taken.
    task automatic send_beat(input logic [DATA_W-1:0] d, input logic last, input string tag);
        int n = 0;
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = last;
        while (!s_axis_tready && n < 2000) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: got tready low for %0d cycles, expected accept", tag, n);
            s_axis_tvalid = 1'b0;
            return;
        end
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (last) chk({tag, "_latency_tvalid"}, m_axis_tvalid, 1);
    endtask

    task automatic send_pair(input logic [7:0] k, input logic [15:0] v, input logic last,
                             input bit use_model);
        send_beat(noisy({8'h00, k}, 1'b1), 1'b0, "key");
        send_beat(noisy(v, 1'b0), last, "val");
        if (use_model) begin
            model_val(k, v);
            if (last) push_model();
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && n < 500) begin
            @(negedge aclk);
            #3;
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL %s_drain: got %0d beats outstanding, expected 0", tag, exp_q.size());
            exp_q.delete();
        end
        @(negedge aclk);
        #3;
    endtask

    initial begin
        exp_t e;
        int   base;
        int   n;

        vecs[0] = '{8'd1,   16'd5,      0,  24'd5};
        vecs[1] = '{8'd12,  16'hFFFF,   11, 24'h00FFFF};
        vecs[2] = '{8'd0,   16'd7,      -1, 24'd0};
        vecs[3] = '{8'd13,  16'd9,      -1, 24'd0};
        vecs[4] = '{8'd255, 16'd1,      -1, 24'd0};
        vecs[5] = '{8'd7,   16'd0,      6,  24'd0};
        vecs[6] = '{8'd6,   16'h1234,   5,  24'h001234};
        vecs[7] = '{8'd16,  16'd2,      -1, 24'd0};
        vecs[8] = '{8'd17,  16'd3,      -1, 24'd0};

        model_clear();
        repeat (3) @(negedge aclk);
        chk("rst_s_tready", s_axis_tready, 0);
        chk("rst_m_tvalid", m_axis_tvalid, 0);
        chk("rst_m_tlast", m_axis_tlast, 0);
        chk("rst_m_tdata", m_axis_tdata, 0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("release_s_tready", s_axis_tready, 1);

        // Baseline frame, then the same frame under backpressure.
        for (int k = 1; k <= 12; k++) send_pair(8'(k), 16'h009E, k == 12, 1'b1);
        drain("baseline");
        bp_en = 1'b1;
        for (int k = 1; k <= 12; k++) send_pair(8'(k), 16'h009E, k == 12, 1'b1);
        drain("backpressure");
        bp_en = 1'b0;

        // Accumulation with invalid keys.
        send_pair(8'd3, 16'd100, 1'b0, 1'b1);
        send_pair(8'd3, 16'd50, 1'b0, 1'b1);
        send_pair(8'd0, 16'd7, 1'b0, 1'b1);
        send_pair(8'd13, 16'd9, 1'b0, 1'b1);
        send_pair(8'd12, 16'd1, 1'b1, 1'b1);
        drain("accum");

        // Saturation, then a frame proving the bins were cleared.
        for (int i = 0; i < 300; i++) send_pair(8'd5, 16'hFFFF, i == 299, 1'b1);
        drain("saturate");
        send_pair(8'd1, 16'd1, 1'b1, 1'b1);
        drain("post_clear");

        // Tlast on a key beat.
        send_pair(8'd1, 16'd10, 1'b0, 1'b1);
        send_beat(noisy(16'h0002, 1'b1), 1'b1, "keylast");
        push_model();
        drain("keylast");

        // One-pair frames with table expectations.
        for (int t = 0; t < 9; t++) begin
            send_pair(vecs[t].key, vecs[t].val, 1'b1, 1'b0);
            for (int i = 0; i < 12; i++) begin
                e.val  = (i == vecs[t].bin) ? vecs[t].expv : '0;
                e.last = (i == 11);
                exp_q.push_back(e);
            end
            drain("table");
        end

        // Reset after output beat 5 of a frame is accepted.
        base = out_beats;
        for (int k = 1; k <= 12; k++) send_pair(8'(k), 16'(k * 3), k == 12, 1'b1);
        n = 0;
        while (out_beats < base + 5 && n < 200) begin
            @(negedge aclk);
            #3;
            n++;
        end
        chk("midemit_beats_seen", 32'(out_beats - base), 5);
        @(negedge aclk);
        aresetn = 1'b0;
        exp_q.delete();
        model_clear();
        repeat (2) @(negedge aclk);
        chk("midemit_rst_m_tvalid", m_axis_tvalid, 0);
        chk("midemit_rst_s_tready", s_axis_tready, 0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("midemit_release_s_tready", s_axis_tready, 1);
        chk("midemit_release_m_tvalid", m_axis_tvalid, 0);
        send_pair(8'd2, 16'd3, 1'b1, 1'b1);
        drain("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
